fetch_unit: RTL

- Instruction fetch stage directly upstream of the processor datapath.
- Holds the PC and issues one-at-a-time requests to instruction memory over a req/gnt/rvalid protocol.
- Buffers returned instructions with their PC in a small FIFO and hands them to decode over a valid/ready handshake.
- Accepts PC redirects (branch/jump) from execute, flushing stale instructions.

---
 rtl/fetch_unit_if.sv | 28 ++
 rtl/fetch_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction-memory req/gnt/rvalid channel, execute redirect,
// and the valid/ready instruction handoff to decode.
interface fetch_unit_if #(
    parameter int WORDSIZE         = 64,
    parameter int INSTRUCTION_SIZE = 32
);
    logic                        imem_req;
    logic [WORDSIZE-1:0]         imem_addr;
    logic                        imem_gnt;
    logic                        imem_rvalid;
    logic [INSTRUCTION_SIZE-1:0] imem_rdata;
    logic                        redirect_valid;
    logic [WORDSIZE-1:0]         redirect_pc;
    logic                        inst_valid;
    logic                        inst_ready;
    logic [INSTRUCTION_SIZE-1:0] inst;
    logic [WORDSIZE-1:0]         inst_pc;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, FIFO of {inst, pc} toward decode,
// redirect flush. Define FETCH_MISALIGN_EN to add the fetch_misalign output and stall.
module fetch_unit #(
    parameter int                  WORDSIZE         = 64,
    parameter int                  INSTRUCTION_SIZE = 32,
    parameter logic [WORDSIZE-1:0] RESET_PC         = '0,
    parameter int                  FIFO_DEPTH       = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    fetch_unit_if.master bus
`ifdef FETCH_MISALIGN_EN
    ,
    output logic         fetch_misalign
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t                      state;
    logic                        req_q;
    logic                        discard;
    logic [WORDSIZE-1:0]         pc;
    logic [WORDSIZE-1:0]         req_pc;

    logic [INSTRUCTION_SIZE-1:0] fifo_inst [FIFO_DEPTH];
    logic [WORDSIZE-1:0]         fifo_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0]            head;
    logic [PTR_W-1:0]            tail;
    logic [CNT_W-1:0]            count;

    logic [WORDSIZE-1:0]         redir_tgt;
    logic                        misalign_hit;
    logic                        blocked;
    logic                        has_space;
    logic                        push;
    logic                        pop;

`ifdef FETCH_MISALIGN_EN
    logic misalign_q;

    assign redir_tgt      = bus.redirect_pc;
    assign misalign_hit   = (bus.redirect_pc[1:0] != 2'b00);
    assign blocked        = misalign_q;
    assign fetch_misalign = misalign_q;

    // Sticky until the next redirect re-evaluates alignment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            misalign_q <= 1'b0;
        else if (bus.redirect_valid)
            misalign_q <= misalign_hit;
    end
`else
    assign redir_tgt    = bus.redirect_pc & ~WORDSIZE'(3);
    assign misalign_hit = 1'b0;
    assign blocked      = 1'b0;
`endif

    // Only one request is ever in flight, so in IDLE the count alone decides space.
    assign has_space = (count < CNT_W'(FIFO_DEPTH));
    assign push      = (state == WAIT) && bus.imem_rvalid && !discard && !bus.redirect_valid;
    assign pop       = (count != '0) && bus.inst_ready && !bus.redirect_valid;

    assign bus.imem_req   = req_q;
    assign bus.imem_addr  = pc;
    assign bus.inst_valid = (count != '0);
    assign bus.inst       = fifo_inst[head];
    assign bus.inst_pc    = fifo_pc[head];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            req_q   <= 1'b0;
            discard <= 1'b0;
            pc      <= RESET_PC;
            req_pc  <= '0;
        end else begin
            if (bus.redirect_valid)
                pc <= redir_tgt;
            else if (state == REQ && bus.imem_gnt)
                pc <= pc + WORDSIZE'(4);

            case (state)
                IDLE: begin
                    if (bus.redirect_valid) begin
                        if (!misalign_hit) begin
                            state <= REQ;
                            req_q <= 1'b1;
                        end
                    end else if (has_space && !blocked) begin
                        state <= REQ;
                        req_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus.imem_gnt) begin
                        state   <= WAIT;
                        req_q   <= 1'b0;
                        req_pc  <= pc;
                        discard <= bus.redirect_valid;
                    end else if (bus.redirect_valid && misalign_hit) begin
                        state <= IDLE;
                        req_q <= 1'b0;
                    end
                end
                WAIT: begin
                    // A response coinciding with a redirect is consumed here and dropped.
                    if (bus.imem_rvalid) begin
                        state   <= IDLE;
                        discard <= 1'b0;
                    end else if (bus.redirect_valid) begin
                        discard <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_inst[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else if (bus.redirect_valid) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                fifo_inst[tail] <= bus.imem_rdata;
                fifo_pc[tail]   <= req_pc;
                tail            <= tail + PTR_W'(1);
            end
            if (pop)
                head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule
